// File: rtl/i2c_eeprom_seq.sv
// i2c_eeprom_seq: APB-master sequencer that turns single EEPROM read/write
// requests (16-bit address, 1..8 bytes) into i2c_master_apb CMD/DATA
// register traffic, waits out the write cycle and collects read bytes.
module i2c_eeprom_seq #(
    parameter logic [6:0]  DEV_ADDR     = 7'h55,
    parameter int unsigned PRESCALE     = 25,
    parameter int unsigned TWR_CYCLES   = 60000,
    parameter int unsigned POLL_TIMEOUT = 4096
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [3:0]  req_len,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [63:0] rsp_rdata,
    output logic [31:0] M_PADDR,
    output logic        M_PSEL,
    output logic        M_PENABLE,
    output logic        M_PWRITE,
    output logic [31:0] M_PWDATA,
    input  logic [31:0] M_PRDATA,
    input  logic        M_PREADY
);

    localparam logic [31:0] ADDR_CMD      = 32'h04;
    localparam logic [31:0] ADDR_DATA     = 32'h08;
    localparam logic [31:0] ADDR_PRESCALE = 32'h0C;
    localparam logic [31:0] DEV32         = {25'd0, DEV_ADDR};
    localparam logic [31:0] CMD_WR        = 32'h0400 | DEV32;
    localparam logic [31:0] CMD_RD        = 32'h0200 | DEV32;
    localparam logic [31:0] CMD_RD_STOP   = 32'h1200 | DEV32;
    localparam logic [31:0] CMD_STOP      = 32'h1000 | DEV32;

    typedef enum logic [2:0] {
        S_RESET_INIT,
        S_IDLE,
        S_CHECK,
        S_WR_SEQ,
        S_TWR_WAIT,
        S_RD_SEQ,
        S_POLL,
        S_RESP
    } state_t;

    typedef struct packed {
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] paddr;
        logic [31:0] pwdata;
    } apb_t;

    // Setup-phase bus values for a new transfer.
    function automatic apb_t apb_setup(input logic [31:0] a, input logic [31:0] d,
                                       input logic w);
        apb_t t;
        t.psel    = 1'b1;
        t.penable = 1'b0;
        t.pwrite  = w;
        t.paddr   = a;
        t.pwdata  = d;
        return t;
    endfunction

    // Transfer number idx of a write or read command sequence.
    // Returns {is_cmd, data}; is_cmd selects CMD vs DATA register.
    function automatic logic [32:0] seq_xfer(input logic wr, input logic [4:0] idx,
                                             input logic [3:0] len, input logic [15:0] addr,
                                             input logic [63:0] wdata);
        logic [4:0]  bidx;
        logic [32:0] r;
        r    = {1'b1, CMD_WR};
        bidx = '0;
        if (idx == 5'd1) begin
            r = {1'b0, 24'd0, addr[15:8]};
        end else if (wr) begin
            if (idx == 5'd3) begin
                r = {1'b0, 24'd0, addr[7:0]};
            end else if (idx[0]) begin
                bidx = (idx - 5'd5) >> 1;
                r = {1'b0, 22'd0, (bidx == ({1'b0, len} - 5'd1)), 1'b0,
                     wdata[{bidx[2:0], 3'b000} +: 8]};
            end else if (idx == ({len, 1'b0} + 5'd4)) begin
                r = {1'b1, CMD_STOP};
            end
        end else begin
            if (idx == 5'd3) begin
                r = {1'b0, 22'd0, 1'b1, 1'b0, addr[7:0]};
            end else if (idx >= 5'd4) begin
                bidx = idx - 5'd4;
                r = (bidx == ({1'b0, len} - 5'd1)) ? {1'b1, CMD_RD_STOP} : {1'b1, CMD_RD};
            end
        end
        return r;
    endfunction

    state_t      state, state_n;
    apb_t        bus, bus_n;
    logic [4:0]  step, step_n;
    logic        r_write, r_write_n;
    logic [15:0] r_addr, r_addr_n;
    logic [3:0]  r_len, r_len_n;
    logic [63:0] r_wdata, r_wdata_n;
    logic [63:0] rd_buf, rd_buf_n;
    logic [3:0]  k, k_n;
    logic [31:0] cnt, cnt_n;
    logic        err_q, err_n;
    logic [63:0] rdata_q, rdata_n;

    logic        apb_done;
    logic [4:0]  last_idx;
    logic [32:0] nx_xfer;
    logic        req_bad;
    logic        prdata_unused;

    assign apb_done = bus.psel && bus.penable && M_PREADY;
    assign last_idx = r_write ? ({r_len, 1'b0} + 5'd4) : ({1'b0, r_len} + 5'd3);
    assign nx_xfer  = seq_xfer(r_write, step + 5'd1, r_len, r_addr, r_wdata);
    assign req_bad  = (r_len == 4'd0) || (r_len > 4'd8) ||
                      (r_write && (({2'b00, r_addr[4:0]} + {3'b000, r_len}) > 7'd32));
    assign prdata_unused = ^M_PRDATA[31:9];

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign rsp_err   = err_q;
    assign rsp_rdata = rdata_q;
    assign M_PSEL    = bus.psel;
    assign M_PENABLE = bus.penable;
    assign M_PWRITE  = bus.pwrite;
    assign M_PADDR   = bus.paddr;
    assign M_PWDATA  = bus.pwdata;

    // Next-state, APB bus and datapath updates.
    always_comb begin
        state_n   = state;
        bus_n     = bus;
        step_n    = step;
        r_write_n = r_write;
        r_addr_n  = r_addr;
        r_len_n   = r_len;
        r_wdata_n = r_wdata;
        rd_buf_n  = rd_buf;
        k_n       = k;
        cnt_n     = cnt;
        err_n     = err_q;
        rdata_n   = rdata_q;

        case (state)
            S_RESET_INIT: begin
                if (!bus.psel) begin
                    bus_n = apb_setup(ADDR_PRESCALE, 32'(PRESCALE), 1'b1);
                end else if (!bus.penable) begin
                    bus_n.penable = 1'b1;
                end else if (apb_done) begin
                    bus_n   = '0;
                    state_n = S_IDLE;
                end
            end
            S_IDLE: begin
                if (req_valid) begin
                    r_write_n = req_write;
                    r_addr_n  = req_addr;
                    r_len_n   = req_len;
                    r_wdata_n = req_wdata;
                    state_n   = S_CHECK;
                end
            end
            S_CHECK: begin
                rd_buf_n = '0;
                k_n      = '0;
                step_n   = '0;
                if (req_bad) begin
                    err_n   = 1'b1;
                    rdata_n = '0;
                    state_n = S_RESP;
                end else begin
                    bus_n   = apb_setup(ADDR_CMD, CMD_WR, 1'b1);
                    state_n = r_write ? S_WR_SEQ : S_RD_SEQ;
                end
            end
            S_WR_SEQ, S_RD_SEQ: begin
                if (bus.psel && !bus.penable) begin
                    bus_n.penable = 1'b1;
                end else if (apb_done) begin
                    if (step == last_idx) begin
                        cnt_n = '0;
                        if (r_write) begin
                            bus_n   = '0;
                            state_n = S_TWR_WAIT;
                        end else begin
                            bus_n   = apb_setup(ADDR_DATA, 32'd0, 1'b0);
                            state_n = S_POLL;
                        end
                    end else begin
                        step_n = step + 5'd1;
                        bus_n  = apb_setup(nx_xfer[32] ? ADDR_CMD : ADDR_DATA,
                                           nx_xfer[31:0], 1'b1);
                    end
                end
            end
            S_TWR_WAIT: begin
                if (cnt == 32'(TWR_CYCLES - 1)) begin
                    err_n   = 1'b0;
                    rdata_n = rd_buf;
                    state_n = S_RESP;
                end else begin
                    cnt_n = cnt + 32'd1;
                end
            end
            S_POLL: begin
                if (bus.psel && !bus.penable) begin
                    bus_n.penable = 1'b1;
                end else if (apb_done) begin
                    bus_n = '0;
                    if (M_PRDATA[8]) begin
                        rd_buf_n[{k[2:0], 3'b000} +: 8] = M_PRDATA[7:0];
                        if ((k + 4'd1) == r_len) begin
                            err_n   = 1'b0;
                            rdata_n = rd_buf_n;
                            state_n = S_RESP;
                        end else begin
                            k_n   = k + 4'd1;
                            cnt_n = '0;
                            bus_n = apb_setup(ADDR_DATA, 32'd0, 1'b0);
                        end
                    end else if ((cnt + 32'd1) == 32'(POLL_TIMEOUT)) begin
                        err_n   = 1'b1;
                        rdata_n = rd_buf;
                        state_n = S_RESP;
                    end else begin
                        cnt_n = cnt + 32'd1;
                        bus_n = apb_setup(ADDR_DATA, 32'd0, 1'b0);
                    end
                end
            end
            S_RESP: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_RESET_INIT;
                bus_n   = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state   <= S_RESET_INIT;
            bus     <= '0;
            step    <= '0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_len   <= '0;
            r_wdata <= '0;
            rd_buf  <= '0;
            k       <= '0;
            cnt     <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state   <= state_n;
            bus     <= bus_n;
            step    <= step_n;
            r_write <= r_write_n;
            r_addr  <= r_addr_n;
            r_len   <= r_len_n;
            r_wdata <= r_wdata_n;
            rd_buf  <= rd_buf_n;
            k       <= k_n;
            cnt     <= cnt_n;
            err_q   <= err_n;
            rdata_q <= rdata_n;
        end
    end

endmodule

// File: doc/i2c_eeprom_seq.md
# i2c_eeprom_seq

APB-master sequencer that drives the `i2c_master_apb` register interface to perform complete 24AA64-style EEPROM transactions: 16-bit memory addressing, 1–8 byte writes and reads. It accepts one request at a time on a valid/ready port and emits the required CMD/DATA register writes. For writes it waits out the EEPROM write cycle. For reads it polls the RX FIFO and returns the bytes as a single response. It sits between a system-side client and the I2C master, replacing software register sequencing.

## Interface
Parameters:
- `DEV_ADDR`, 7'h55: 7-bit I2C device address placed in CMD[6:0].
- `PRESCALE`, 25: value written to PRESCALE (0x0C) once after reset (100 kHz at 10 MHz PCLK).
- `TWR_CYCLES`, 60000: post-write wait in PCLK cycles (6 ms at 10 MHz).
- `POLL_TIMEOUT`, 4096: maximum APB polls per read byte before error.

Ports (one clock; reset is synchronous and active-high):
- `PCLK` in 1: clock.
- `PRESET` in 1: synchronous active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block idle and initialised.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 16: EEPROM memory address.
- `req_len` in 4: byte count, legal 1..8.
- `req_wdata` in 64: write bytes; byte i on [8i+7:8i], byte 0 sent first.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_err` out 1: qualified by `rsp_valid`.
- `rsp_rdata` out 64: read bytes, same packing as `req_wdata`; unread bytes are 0.
- `M_PADDR` out 32, `M_PSEL` out 1, `M_PENABLE` out 1, `M_PWRITE` out 1, `M_PWDATA` out 32: APB master outputs.
- `M_PRDATA` in 32, `M_PREADY` in 1: APB master inputs.

## Operation
Register map used:
- CMD 0x04: [6:0] addr, [9] read, [10] write, [12] stop.
- DATA 0x08, write: [7:0] byte, [9] last.
- DATA 0x08, read: [7:0] byte, [8] valid.
- PRESCALE 0x0C.

States: RESET_INIT → IDLE → CHECK → (WR_SEQ | RD_SEQ) → (TWR_WAIT | POLL) → RESP → IDLE.

- RESET_INIT: a single APB write of `PRESCALE` to 0x0C. `req_ready` stays 0 until it completes.
- CHECK: rejects the request with `rsp_err`=1 and no APB traffic if any of the following holds:
  - `req_len`=0 or `req_len`>8;
  - a write with `req_addr[4:0]+req_len>32` (page crossing; the block does not split pages).
- WR_SEQ issues APB writes in this order:
  - CMD 0x455 / DATA addr[15:8];
  - CMD 0x455 / DATA addr[7:0];
  - for each byte i: CMD 0x455 / DATA byte_i, with [9]=1 on the last byte;
  - CMD 0x1000|DEV_ADDR (stop).
  - Total 2·(len+2)+1 APB writes.
- TWR_WAIT: counts `TWR_CYCLES` cycles, then goes to RESP with err=0.
- RD_SEQ issues APB writes in this order:
  - CMD 0x455 / DATA addr[15:8];
  - CMD 0x455 / DATA 0x200|addr[7:0];
  - len−1 × CMD 0x255, then one CMD 0x1255 (read+stop).
- POLL: APB-reads DATA repeatedly.
  - On [8]=1, store [7:0] into byte slot k, k++, and reset the poll counter.
  - When k==len, go to RESP with err=0.
  - When the poll counter reaches `POLL_TIMEOUT` for one byte, go to RESP with err=1 and keep the bytes already captured.
- A request is accepted only on `req_valid && req_ready`. Inputs are latched at acceptance; changes after that are ignored.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0, all `M_*` outputs 0.
- APB transfer: a setup cycle (PSEL=1, PENABLE=0), then access cycles (PENABLE=1) until PREADY=1.
  - PADDR/PWRITE/PWDATA are held stable across the whole transfer.
  - The next transfer's setup cycle follows the completion cycle immediately, with no idle cycle between transfers of one sequence.
  - `M_PRDATA` is sampled on the completion cycle.
- Acceptance: the first APB setup cycle is the cycle after CHECK, i.e. 2 cycles after acceptance. A rejected request gets `rsp_valid` 2 cycles after acceptance.
- `req_ready` drops the cycle after acceptance. It rises on the cycle after the `rsp_valid` pulse, so back-to-back requests are separated by at least one idle cycle.
- `rsp_rdata`/`rsp_err` are valid with `rsp_valid` and hold until the next response.
- TWR_WAIT counts exactly `TWR_CYCLES` cycles, starting the cycle after the stop write completes.
- PREADY held low indefinitely stalls the block; there is no APB timeout.
- `PRESET` mid-transfer: every output returns to its reset value on the next edge, the transaction is abandoned, and RESET_INIT is re-run.

## Test plan
- Reset release → exactly one APB write, PADDR=0x0C, PWDATA=25; `req_ready`=1 one cycle after it completes.
- Write, addr 0x0000, len 3, wdata 0x302010 → APB write sequence:
  - 0x04:0x455, 0x08:0x00;
  - 0x04:0x455, 0x08:0x00;
  - 0x04:0x455, 0x08:0x10;
  - 0x04:0x455, 0x08:0x20;
  - 0x04:0x455, 0x08:0x230;
  - 0x04:0x1055.
  - Then `rsp_valid` TWR_CYCLES+1 cycles after the stop write completes, with err=0.
- Read, addr 0x0000, len 3, EEPROM model preloaded 10/20/30 → `rsp_rdata`=0x302010, err=0. The bench checks the CMD write sequence ends with 0x1255.
- Illegal requests: `req_len`=0, `req_len`=9, and write addr 0x001E len 4 → each gives `rsp_err`=1 with zero APB transfers.
- Bench APB slave with random 0–5 PREADY wait states → protocol checker passes (stable setup/access signals) and the write data matches the unstalled run.
- Read with the slave never setting DATA[8] → err=1 after POLL_TIMEOUT polls. Also assert `PRESET` during WR_SEQ → APB outputs are 0 next cycle, and the prescale write recurs after release.
